ieee: RTL and testbench
=======================

// Module: ieee
// PURPOSE
//   Single-precision IEEE-754 adder/subtractor, 4-stage pipeline, one result per clock.
//   Computes number1 + number2 (command=1) or number1 - number2 (command=0).
//   Result is output as separate sign/exponent/fraction fields for the downstream packer.
//   No handshake: operands are sampled every rising clk edge.
// PARAMETERS
//   none (format fixed at binary32: 1 sign, 8 exponent, 23 fraction, bias 127)
// PORTS
//   clk      in   1   rising-edge clock (single clock domain)
//   rst      in   1   reset, asynchronous, active-high
//   command  in   1   1 = add, 0 = subtract (number1 - number2)
//   number1  in   32  operand A, IEEE-754 binary32
//   number2  in   32  operand B, IEEE-754 binary32
//   sum1     out  1   result sign
//   sum2     out  8   result biased exponent
//   sum3     out  23  result fraction (hidden bit not included)
// BEHAVIOUR
// - Reset: rst=1 asynchronously clears all pipeline registers; sum1=0, sum2=0, sum3=0
//   (+0.0) while held and until the first valid operand reaches the output. Reset mid-
//   operation discards all in-flight results; no partial result is ever output.
// - Latency: operands sampled at edge N appear on sum1/sum2/sum3 after edge N+4;
//   throughput 1/clock. Outputs registered, hold value while operands are stable.
// - Stage 1: unpack, restore hidden bit; exp==0 (zero/denormal) -> operand = 0
//   (flush-to-zero). For subtract invert sign of B. Classify NaN/Inf. Swap so that
//   |A| >= |B| (compare exp then fraction).
// - Stage 2: shift smaller significand right by exp difference (diff >= 26 -> only
//   sticky remains); keep guard, round and sticky (OR of all shifted-out bits).
// - Stage 3: effective add if signs equal, else subtract smaller from larger
//   (result sign = sign of larger magnitude). 25-bit sum plus G/R/S.
// - Stage 4: normalise: carry-out -> shift right 1, exp+1; else leading-zero count,
//   shift left, exp-lzc. Round to nearest, ties to even; rounding carry renormalises.
// - Exact cancellation (incl. x - x, x + (-x)) -> +0 (sign 0, exp 0, frac 0).
// - Underflow (normalised exp <= 0) -> signed zero (flush-to-zero, no denormals out).
// - Overflow (exp >= 255 after round) -> signed infinity (exp 0xFF, frac 0).
// - Any NaN input, or Inf + (-Inf) effective subtract -> quiet NaN: sign 0,
//   exp 0xFF, frac 0x400000. Inf with finite -> that Inf (sign after command).
// - Zero operand: result = other operand exactly (0+0 -> +0; -0 + -0 -> -0).
// - No exception flags; no stall/enable; X on inputs is not filtered.
// TESTING
// - rst pulse mid-stream, then release -> outputs 0/0/0 immediately, next valid
//   result appears exactly 4 edges after its operands are sampled.
// - cmd=1, A=0xBF8E182F, B=0x3F8E17C2 -> sum1=1, sum2=8'h6E, sum3=23'h5A0000
//   (massive cancellation, lzc normalise).
// - cmd=1, A=B=0xBF800054 -> sum1=1, sum2=8'h80, sum3=23'h000054; same operands
//   cmd=0 -> 0/8'h00/23'h0 (+0).
// - cmd=1, A=0x40200000 (2.5), B=0x40F00000 (7.5) -> 0/8'h82/23'h200000 (10.0,
//   carry-out renormalise); cmd=0 same operands -> 1/8'h81/23'h200000 (-5.0).
// - Rounding: cmd=1, A=0x3F800000, B=0x33800000 (tie) -> 0/8'h7F/23'h000000;
//   B=0x33800001 -> 0/8'h7F/23'h000001.
// - Specials: 0x7F7FFFFF + 0x7F7FFFFF -> 0/8'hFF/0 (overflow Inf);
//   0x7F800000 + 0xFF800000 -> 0/8'hFF/23'h400000 (NaN); back-to-back distinct
//   operands every clock -> each result in order, 4 cycles later.

Source files
------------

// File: rtl/ieee.sv
// rtl/ieee.sv - single-precision IEEE-754 adder/subtractor, 4-stage pipeline, registered outputs
module ieee (
    input  logic        clk,
    input  logic        rst,
    input  logic        command,
    input  logic [31:0] number1,
    input  logic [31:0] number2,
    output logic        sum1,
    output logic [7:0]  sum2,
    output logic [22:0] sum3
);
    // operand capture
    logic        in_cmd;
    logic [31:0] in_a, in_b;

    // stage 1: unpack, classify, order by magnitude
    logic        sa, sb, na, nb, ia, ib, a_ge;
    logic [7:0]  ea, eb;
    logic [22:0] fa, fb;

    assign ea   = in_a[30:23];
    assign eb   = in_b[30:23];
    assign fa   = (ea == 8'h00) ? 23'h0 : in_a[22:0];
    assign fb   = (eb == 8'h00) ? 23'h0 : in_b[22:0];
    assign sa   = in_a[31];
    assign sb   = in_b[31] ^ ~in_cmd;
    assign na   = (&ea) & (|fa);
    assign nb   = (&eb) & (|fb);
    assign ia   = (&ea) & ~(|fa);
    assign ib   = (&eb) & ~(|fb);
    assign a_ge = {ea, fa} >= {eb, fb};

    logic        s1_sign, s1_sub, s1_nan, s1_inf, s1_inf_sign;
    logic [7:0]  s1_exp, s1_diff;
    logic [23:0] s1_mbig, s1_msml;

    // stage 2: align smaller significand, keep guard/round/sticky
    logic [49:0] align_sh;
    logic [23:0] al_m;
    logic [2:0]  al_grs;

    assign align_sh = {s1_msml, 26'h0} >> s1_diff;

    always_comb begin
        al_m   = align_sh[49:26];
        al_grs = {align_sh[25], align_sh[24], |align_sh[23:0]};
        if (s1_diff >= 8'd26) begin
            al_m   = 24'h0;
            al_grs = {2'b00, |s1_msml};
        end
    end

    logic        s2_sign, s2_sub, s2_nan, s2_inf, s2_inf_sign;
    logic [7:0]  s2_exp;
    logic [23:0] s2_mbig, s2_msml;
    logic [2:0]  s2_grs;

    // stage 3: significand add/subtract, frame is {carry, 24-bit mantissa, G, R, S}
    logic [27:0] op_big, op_sml;

    assign op_big = {1'b0, s2_mbig, 3'b000};
    assign op_sml = {1'b0, s2_msml, s2_grs};

    logic        s3_sign, s3_sub, s3_nan, s3_inf, s3_inf_sign;
    logic [7:0]  s3_exp;
    logic [27:0] s3_sum;

    // stage 4: normalise, round to nearest even, resolve specials
    logic [4:0]  lzc;
    logic [26:0] nsh;
    logic [23:0] mant;
    logic        rg, rst_bit;
    logic [24:0] mr;
    logic [9:0]  e_n, e_r;
    logic [22:0] frac_r;
    logic        r_sign;
    logic [7:0]  r_exp;
    logic [22:0] r_frac;

    always_comb begin
        lzc = 5'd0;
        for (int i = 0; i < 27; i++) begin
            if (s3_sum[i]) lzc = 5'(26 - i);
        end
        nsh = s3_sum[26:0] << lzc;
        if (s3_sum[27]) begin
            mant    = s3_sum[27:4];
            rg      = s3_sum[3];
            rst_bit = |s3_sum[2:0];
            e_n     = {2'b00, s3_exp} + 10'd1;
        end else begin
            mant    = nsh[26:3];
            rg      = nsh[2];
            rst_bit = |nsh[1:0];
            e_n     = {2'b00, s3_exp} - {5'b00000, lzc};
        end
        mr     = {1'b0, mant} + {24'h0, rg & (rst_bit | mant[0])};
        e_r    = e_n + {9'h0, mr[24]};
        frac_r = mr[24] ? mr[23:1] : mr[22:0];

        r_sign = s3_sign;
        r_exp  = e_r[7:0];
        r_frac = frac_r;
        if (s3_nan) begin
            r_sign = 1'b0;
            r_exp  = 8'hFF;
            r_frac = 23'h400000;
        end else if (s3_inf) begin
            r_sign = s3_inf_sign;
            r_exp  = 8'hFF;
            r_frac = 23'h0;
        end else if (s3_sum == 28'h0) begin
            // cancellation gives +0; only like-signed zeros keep their sign
            r_sign = s3_sub ? 1'b0 : s3_sign;
            r_exp  = 8'h00;
            r_frac = 23'h0;
        end else if (e_r[9] || e_r == 10'd0) begin
            r_exp  = 8'h00;
            r_frac = 23'h0;
        end else if (e_r >= 10'd255) begin
            r_exp  = 8'hFF;
            r_frac = 23'h0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_cmd      <= 1'b0;
            in_a        <= 32'h0;
            in_b        <= 32'h0;
            s1_sign     <= 1'b0;
            s1_sub      <= 1'b0;
            s1_nan      <= 1'b0;
            s1_inf      <= 1'b0;
            s1_inf_sign <= 1'b0;
            s1_exp      <= 8'h0;
            s1_diff     <= 8'h0;
            s1_mbig     <= 24'h0;
            s1_msml     <= 24'h0;
            s2_sign     <= 1'b0;
            s2_sub      <= 1'b0;
            s2_nan      <= 1'b0;
            s2_inf      <= 1'b0;
            s2_inf_sign <= 1'b0;
            s2_exp      <= 8'h0;
            s2_mbig     <= 24'h0;
            s2_msml     <= 24'h0;
            s2_grs      <= 3'b000;
            s3_sign     <= 1'b0;
            s3_sub      <= 1'b0;
            s3_nan      <= 1'b0;
            s3_inf      <= 1'b0;
            s3_inf_sign <= 1'b0;
            s3_exp      <= 8'h0;
            s3_sum      <= 28'h0;
            sum1        <= 1'b0;
            sum2        <= 8'h0;
            sum3        <= 23'h0;
        end else begin
            in_cmd      <= command;
            in_a        <= number1;
            in_b        <= number2;

            s1_sign     <= a_ge ? sa : sb;
            s1_sub      <= sa ^ sb;
            s1_nan      <= na | nb | (ia & ib & (sa ^ sb));
            s1_inf      <= ia | ib;
            s1_inf_sign <= ia ? sa : sb;
            s1_exp      <= a_ge ? ea : eb;
            s1_diff     <= a_ge ? (ea - eb) : (eb - ea);
            s1_mbig     <= a_ge ? {|ea, fa} : {|eb, fb};
            s1_msml     <= a_ge ? {|eb, fb} : {|ea, fa};

            s2_sign     <= s1_sign;
            s2_sub      <= s1_sub;
            s2_nan      <= s1_nan;
            s2_inf      <= s1_inf;
            s2_inf_sign <= s1_inf_sign;
            s2_exp      <= s1_exp;
            s2_mbig     <= s1_mbig;
            s2_msml     <= al_m;
            s2_grs      <= al_grs;

            s3_sign     <= s2_sign;
            s3_sub      <= s2_sub;
            s3_nan      <= s2_nan;
            s3_inf      <= s2_inf;
            s3_inf_sign <= s2_inf_sign;
            s3_exp      <= s2_exp;
            s3_sum      <= s2_sub ? (op_big - op_sml) : (op_big + op_sml);

            sum1        <= r_sign;
            sum2        <= r_exp;
            sum3        <= r_frac;
        end
    end
endmodule

// File: tb/tb_ieee.sv
// tb/tb_ieee.sv - scoreboard bench for the ieee adder/subtractor pipeline
module tb_ieee;
    logic        clk;
    logic        rst;
    logic        command;
    logic [31:0] number1, number2;
    logic        sum1;
    logic [7:0]  sum2;
    logic [22:0] sum3;

    ieee dut (
        .clk     (clk),
        .rst     (rst),
        .command (command),
        .number1 (number1),
        .number2 (number2),
        .sum1    (sum1),
        .sum2    (sum2),
        .sum3    (sum3)
    );

    typedef struct {
        int          due;
        int          id;
        logic        s;
        logic [7:0]  e;
        logic [22:0] f;
    } exp_t;

    typedef struct {
        logic        cmd;
        logic [31:0] a;
        logic [31:0] b;
        logic        s;
        logic [7:0]  e;
        logic [22:0] f;
    } vec_t;

    exp_t sb_q[$];
    vec_t vecs[$];
    int   cyc     = 0;
    int   n_check = 0;
    int   n_fail  = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // monitor: compare the oldest expectation on the cycle it falls due
    always @(negedge clk) begin
        if (!rst && sb_q.size() > 0) begin
            if (sb_q[0].due == cyc) begin
                n_check++;
                if ({sum1, sum2, sum3} !== {sb_q[0].s, sb_q[0].e, sb_q[0].f}) begin
                    n_fail++;
                    $display("FAIL vec%0d: got %0b/%02h/%06h required %0b/%02h/%06h",
                             sb_q[0].id, sum1, sum2, sum3, sb_q[0].s, sb_q[0].e, sb_q[0].f);
                end
                void'(sb_q.pop_front());
            end else if (sb_q[0].due < cyc) begin
                n_check++;
                n_fail++;
                $display("FAIL vec%0d: result slot missed at cycle %0d (due %0d)",
                         sb_q[0].id, cyc, sb_q[0].due);
                void'(sb_q.pop_front());
            end
        end
    end

    task automatic send(input int id);
        exp_t x;
        @(negedge clk);
        command = vecs[id].cmd;
        number1 = vecs[id].a;
        number2 = vecs[id].b;
        x.due = cyc + 5;
        x.id  = id;
        x.s   = vecs[id].s;
        x.e   = vecs[id].e;
        x.f   = vecs[id].f;
        sb_q.push_back(x);
    endtask

    task automatic check_zero(input string name);
        n_check++;
        if ({sum1, sum2, sum3} !== 32'h0) begin
            n_fail++;
            $display("FAIL %s: got %0b/%02h/%06h required 0/00/000000", name, sum1, sum2, sum3);
        end
    endtask

    task automatic drain(input string name);
        int k;
        k = 0;
        while (sb_q.size() > 0 && k < 20) begin
            @(negedge clk);
            k++;
        end
        if (sb_q.size() > 0) begin
            n_check++;
            n_fail++;
            $display("FAIL %s: %0d results never arrived, required 0 pending", name, sb_q.size());
            sb_q.delete();
        end
    endtask

    task automatic addv(input logic c, input logic [31:0] a, input logic [31:0] b,
                        input logic s, input logic [7:0] e, input logic [22:0] f);
        vec_t v;
        v.cmd = c; v.a = a; v.b = b; v.s = s; v.e = e; v.f = f;
        vecs.push_back(v);
    endtask

    initial begin
        rst     = 1'b1;
        command = 1'b0;
        number1 = 32'h0;
        number2 = 32'h0;

        addv(1'b1, 32'hBF8E182F, 32'h3F8E17C2, 1'b1, 8'h6E, 23'h5A0000);
        addv(1'b1, 32'hBF800054, 32'hBF800054, 1'b1, 8'h80, 23'h000054);
        addv(1'b0, 32'hBF800054, 32'hBF800054, 1'b0, 8'h00, 23'h000000);
        addv(1'b1, 32'h40200000, 32'h40F00000, 1'b0, 8'h82, 23'h200000);
        addv(1'b0, 32'h40200000, 32'h40F00000, 1'b1, 8'h81, 23'h200000);
        addv(1'b1, 32'h3F800000, 32'h33800000, 1'b0, 8'h7F, 23'h000000);
        addv(1'b1, 32'h3F800000, 32'h33800001, 1'b0, 8'h7F, 23'h000001);
        addv(1'b1, 32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 8'hFF, 23'h000000);
        addv(1'b1, 32'h7F800000, 32'hFF800000, 1'b0, 8'hFF, 23'h400000);
        addv(1'b1, 32'h80000000, 32'h80000000, 1'b1, 8'h00, 23'h000000);
        addv(1'b1, 32'h00000000, 32'h40200000, 1'b0, 8'h80, 23'h200000);
        addv(1'b0, 32'h3F800000, 32'h7F800000, 1'b1, 8'hFF, 23'h000000);
        addv(1'b1, 32'h7FC00001, 32'h3F800000, 1'b0, 8'hFF, 23'h400000);
        addv(1'b0, 32'h40400000, 32'h3F800000, 1'b0, 8'h80, 23'h000000);
        addv(1'b1, 32'h00400000, 32'h3F800000, 1'b0, 8'h7F, 23'h000000);
        addv(1'b0, 32'h80000000, 32'h00000000, 1'b1, 8'h00, 23'h000000);

        repeat (3) @(negedge clk);
        check_zero("reset_state");
        @(negedge clk);
        rst = 1'b0;

        // back-to-back: one distinct operand pair every clock
        for (int i = 0; i < vecs.size(); i++) send(i);
        drain("burst_drain");

        // reset mid-stream discards everything in flight
        for (int i = 0; i < 3; i++) send(i);
        @(posedge clk);
        #2;
        rst = 1'b1;
        sb_q.delete();
        #1;
        check_zero("rst_async_clear");
        @(negedge clk);
        check_zero("rst_held");
        @(posedge clk);
        #2;
        rst = 1'b0;

        send(3);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_zero("post_rst_idle");
        end
        drain("post_rst_drain");

        $display("End of test - %0d assertions evaluated, %0d failures", n_check, n_fail);
        $finish;
    end
endmodule
